// File: rtl/output_reordering_if.sv
// output_reordering_if: groups the pair-input and sample-output buses of
// output_reordering. The DUT connects through the slave modport and the
// producer/consumer side through the master modport.
// Optional feature: define OUTPUT_BIN_INDEX_EN to add o_bin_index.

interface output_reordering_if #(
  parameter int N_POINTS = 1024
);

  // Butterfly pair input (cannot be stalled)
  logic        i_valid_in;
  logic [31:0] i_data_a_real;
  logic [31:0] i_data_a_imag;
  logic [31:0] i_data_b_real;
  logic [31:0] i_data_b_imag;

  // Natural-order serial output with ready/valid handshake
  logic        o_valid_out;
  logic        i_ready_in;
  logic [31:0] o_data_real;
  logic [31:0] o_data_imag;
  logic        o_last;
  logic        o_overflow;
`ifdef OUTPUT_BIN_INDEX_EN
  logic [$clog2(N_POINTS)-1:0] o_bin_index;
`endif

  modport master (
`ifdef OUTPUT_BIN_INDEX_EN
    input  o_bin_index,
`endif
    output i_valid_in,
    output i_data_a_real,
    output i_data_a_imag,
    output i_data_b_real,
    output i_data_b_imag,
    output i_ready_in,
    input  o_valid_out,
    input  o_data_real,
    input  o_data_imag,
    input  o_last,
    input  o_overflow
  );

  modport slave (
`ifdef OUTPUT_BIN_INDEX_EN
    output o_bin_index,
`endif
    input  i_valid_in,
    input  i_data_a_real,
    input  i_data_a_imag,
    input  i_data_b_real,
    input  i_data_b_imag,
    input  i_ready_in,
    output o_valid_out,
    output o_data_real,
    output o_data_imag,
    output o_last,
    output o_overflow
  );

endinterface

// File: rtl/output_reordering.sv
// output_reordering: turns butterfly output pairs from the last FFT stage
// into a natural-order serial stream. Two ping-pong banks of N_POINTS x 64
// bits are filled two bins per cycle (bin i and bin i+N/2) and drained one
// bin per transfer through a two-stage read pipeline with ready/valid flow
// control. Frames arriving for a busy bank are dropped pair by pair and
// flagged on o_overflow.
// Optional feature: define OUTPUT_BIN_INDEX_EN to add o_bin_index, the bin
// number of the sample currently on o_data_*.

module output_reordering #(
  parameter int N_POINTS = 1024
) (
  input logic                i_clk,
  input logic                i_reset,
  output_reordering_if.slave bus
);

  localparam int ADDR_W = $clog2(N_POINTS);
  localparam int PAIR_W = ADDR_W - 1;
  localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(N_POINTS / 2 - 1);
  localparam logic [ADDR_W-1:0] LAST_BIN  = ADDR_W'(N_POINTS - 1);

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_t;

  // Bank storage: index is {bank, bin}; contents are never cleared.
  logic [63:0] mem [2*N_POINTS];

  bank_state_t bank_state_q [2];
  bank_state_t bank_state_d [2];

  // Write side
  logic [PAIR_W-1:0] pair_cnt_q;
  logic              wr_bank_q;
  logic              frame_drop_q;
  logic              overflow_q;
  logic              frame_start;
  logic              wr_target_empty;
  logic              wr_accept;
  logic              wr_en;
  logic              wr_drop;
  logic              wr_last_pair;

  // Read side: address generator, read stage (s1), output stage (out)
  logic              rd_bank_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              s1_valid_q;
  logic [63:0]       s1_data_q;
  logic              s1_last_q;
  logic              s1_bank_q;
  logic              out_valid_q;
  logic [63:0]       out_data_q;
  logic              out_last_q;
  logic              out_bank_q;
  logic              out_xfer;
  logic              out_ready;
  logic              s1_ready;
  logic              rd_avail;
  logic              rd_issue;

  // A frame's fate is decided by its first pair: the target bank must be
  // EMPTY then, and the remaining pairs follow that decision.
  assign frame_start     = (pair_cnt_q == '0);
  assign wr_target_empty = (bank_state_q[wr_bank_q] == BANK_EMPTY);
  assign wr_accept       = frame_start ? wr_target_empty : !frame_drop_q;
  assign wr_en           = bus.i_valid_in && wr_accept;
  assign wr_drop         = bus.i_valid_in && !wr_accept;
  assign wr_last_pair    = (pair_cnt_q == LAST_PAIR);

  // Ready propagates backwards combinationally so the pipeline sustains one
  // transfer per cycle and stalls in place when the consumer is not ready.
  assign out_xfer  = out_valid_q && bus.i_ready_in;
  assign out_ready = !out_valid_q || bus.i_ready_in;
  assign s1_ready  = !s1_valid_q || out_ready;
  assign rd_avail  = (bank_state_q[rd_bank_q] == BANK_FULL) ||
                     ((bank_state_q[rd_bank_q] == BANK_DRAINING) && (rd_addr_q != '0));
  assign rd_issue  = rd_avail && s1_ready;

  // Pair counter, write-bank select, per-frame drop decision and overflow pulse.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pair_cnt_q   <= '0;
      wr_bank_q    <= 1'b0;
      frame_drop_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      overflow_q <= wr_drop;
      if (bus.i_valid_in) begin
        pair_cnt_q <= pair_cnt_q + PAIR_W'(1);
        if (frame_start) begin
          frame_drop_q <= !wr_target_empty;
        end
      end
      if (wr_en && wr_last_pair) begin
        wr_bank_q <= ~wr_bank_q;
      end
    end
  end

  // Both bins of an accepted pair land in the write bank in the same cycle.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[{wr_bank_q, 1'b0, pair_cnt_q}] <= {bus.i_data_a_real, bus.i_data_a_imag};
      mem[{wr_bank_q, 1'b1, pair_cnt_q}] <= {bus.i_data_b_real, bus.i_data_b_imag};
    end
  end

  // Per-bank next state: write, read-issue and last-transfer events touch
  // disjoint states, so each bank sees at most one of them at a time.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_state_d[b] = bank_state_q[b];
      case (bank_state_q[b])
        BANK_EMPTY: begin
          if (wr_en && (wr_bank_q == b[0])) begin
            bank_state_d[b] = wr_last_pair ? BANK_FULL : BANK_FILLING;
          end
        end
        BANK_FILLING: begin
          if (wr_en && (wr_bank_q == b[0]) && wr_last_pair) begin
            bank_state_d[b] = BANK_FULL;
          end
        end
        BANK_FULL: begin
          if (rd_issue && (rd_bank_q == b[0])) begin
            bank_state_d[b] = BANK_DRAINING;
          end
        end
        BANK_DRAINING: begin
          if (out_xfer && out_last_q && (out_bank_q == b[0])) begin
            bank_state_d[b] = BANK_EMPTY;
          end
        end
        default: bank_state_d[b] = BANK_EMPTY;
      endcase
    end
  end

  // Bank state registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bank_state_q[0] <= BANK_EMPTY;
      bank_state_q[1] <= BANK_EMPTY;
    end else begin
      bank_state_q[0] <= bank_state_d[0];
      bank_state_q[1] <= bank_state_d[1];
    end
  end

  // Read address generator and read stage; the read bank flips as soon as
  // its last bin is issued so the next full bank follows without a bubble.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rd_bank_q  <= 1'b0;
      rd_addr_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_last_q  <= 1'b0;
      s1_bank_q  <= 1'b0;
    end else begin
      if (s1_ready) begin
        s1_valid_q <= rd_issue;
      end
      if (rd_issue) begin
        s1_data_q <= mem[{rd_bank_q, rd_addr_q}];
        s1_last_q <= (rd_addr_q == LAST_BIN);
        s1_bank_q <= rd_bank_q;
        rd_addr_q <= rd_addr_q + ADDR_W'(1);
        if (rd_addr_q == LAST_BIN) begin
          rd_bank_q <= ~rd_bank_q;
        end
      end
    end
  end

  // Output register: holds its contents while the consumer stalls.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_bank_q  <= 1'b0;
    end else if (out_ready) begin
      out_valid_q <= s1_valid_q;
      out_last_q  <= s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        out_data_q <= s1_data_q;
        out_bank_q <= s1_bank_q;
      end
    end
  end

  assign bus.o_valid_out = out_valid_q;
  assign bus.o_data_real = out_data_q[63:32];
  assign bus.o_data_imag = out_data_q[31:0];
  assign bus.o_last      = out_last_q;
  assign bus.o_overflow  = overflow_q;

`ifdef OUTPUT_BIN_INDEX_EN
  logic [ADDR_W-1:0] s1_bin_q;
  logic [ADDR_W-1:0] out_bin_q;

  // Carry the read address alongside the data so the index tracks o_data_*.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1_bin_q  <= '0;
      out_bin_q <= '0;
    end else begin
      if (rd_issue) begin
        s1_bin_q <= rd_addr_q;
      end
      if (out_ready && s1_valid_q) begin
        out_bin_q <= s1_bin_q;
      end
    end
  end

  assign bus.o_bin_index = out_bin_q;
`endif

endmodule

// File: doc/output_reordering.md
OUTPUT_REORDERING -- requirements
Module: output_reordering

Interface
REQ-001 SHALL have parameter N_POINTS, default 1024, giving the FFT frame length (power of two, 8..1024).
REQ-002 SHALL have port i_clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_reset, input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have port i_valid_in, input, 1 bit, marking one butterfly output pair; it cannot be stalled.
REQ-005 SHALL have ports i_data_a_real, i_data_a_imag, i_data_b_real, i_data_b_imag, input, 32 bits each, fixed-point pair from the last FFT stage.
REQ-006 SHALL have port o_valid_out, output, 1 bit, serial sample valid.
REQ-007 SHALL have port i_ready_in, input, 1 bit, downstream ready; a transfer occurs when o_valid_out and i_ready_in are both 1.
REQ-008 SHALL have ports o_data_real and o_data_imag, output, 32 bits each, the natural-order bin value.
REQ-009 SHALL have port o_last, output, 1 bit, high with bin N_POINTS-1.
REQ-010 SHALL have port o_overflow, output, 1 bit, one-cycle pulse per dropped pair.

Function
REQ-011 SHALL number valid pairs within a frame as i = 0..N_POINTS/2-1; pair i carries bin i on a and bin i+N_POINTS/2 on b; the count wraps to 0 after N_POINTS/2-1.
REQ-012 SHALL contain two banks (ping-pong), each N_POINTS x 64 bits; pair i writes addr i (a) and addr i+N_POINTS/2 (b) in the same cycle.
REQ-013 SHALL run per-bank FSM: EMPTY -> FILLING (first pair written) -> FULL (pair N_POINTS/2-1 written) -> DRAINING (first read issued) -> EMPTY (bin N_POINTS-1 transferred).
REQ-014 SHALL start each frame in the write bank; the write bank toggles after each full frame.
REQ-015 SHALL drop a frame arriving while its target bank is not EMPTY: pulse o_overflow once per pair, keep the pair counter counting, and write the next frame to the same bank if it is EMPTY by then.
REQ-016 SHALL drain banks in fill order, bins 0..N_POINTS-1, one bin per transfer.
REQ-017 SHALL assert o_valid_out with bin 0 exactly 2 cycles after the edge that captured pair N_POINTS/2-1, given the read bank was EMPTY.
REQ-018 SHALL hold o_data_*, o_last and o_valid_out stable while o_valid_out=1 and i_ready_in=0.
REQ-019 SHALL sustain one transfer per cycle under continuous i_ready_in=1, including back-to-back frames across the bank switch with no bubble.
REQ-020 SHALL allow a same-cycle write to one bank and read from the other with no interaction.
REQ-021 SHALL pass data bit-exact, with no scaling or rounding.

Reset
REQ-022 SHALL, on i_reset=1, immediately drive o_valid_out=0, o_last=0, o_overflow=0, o_data_real=0, o_data_imag=0.
REQ-023 SHALL, on reset, set both banks EMPTY, the pair counter to 0 and the write/read bank selects to bank 0; bank contents are not cleared.
REQ-024 SHALL, on reset mid-frame, discard the partial frame and any undrained data; the first valid pair after release is pair 0.

Configuration
REQ-025 SHALL, when OUTPUT_BIN_INDEX_EN is defined, add port o_bin_index (output, log2(N_POINTS) bits, reset 0), equal to the bin number of the current o_data_*.
REQ-026 SHALL, when OUTPUT_BIN_INDEX_EN is undefined, omit o_bin_index; all other behaviour is identical.

Verification
REQ-027 SHALL cover a single frame: N=8, pairs a=k, b=k+4 for k=0..3, ready=1 -> o_data_real 0..7 in order, o_last only on 7, first valid 2 cycles after pair 3.
REQ-028 SHALL cover backpressure: ready toggling 1/0 each cycle during drain -> each bin is held while ready=0, with no loss or duplication.
REQ-029 SHALL cover back-to-back frames: pairs every 2nd cycle, ready=1 -> a continuous bin stream 0..7,0..7 with no gap between frames.
REQ-030 SHALL cover overflow: ready=0 while 3 frames arrive -> frames 1-2 stored, frame 3 produces 4 o_overflow pulses; later draining yields exactly frames 1 and 2.
REQ-031 SHALL cover reset mid-drain: i_reset asserted after bin 3 -> o_valid_out=0 immediately; the next frame drains from bin 0.
REQ-032 SHALL cover OUTPUT_BIN_INDEX_EN: with the macro defined, o_bin_index equals 0..7 tracking the data; with it undefined, the build succeeds without the port.
